// File: rtl/shift_sched.sv
// Two-port job sequencer for a shared 8-bit barrel shifter. Each job is
// split into passes of up to 7 positions, and the result is returned with its requester id.
module shift_sched #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] a_din,
    input  logic [4:0] a_shamt,
    input  logic       a_lorr,
    input  logic       a_aorl,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [7:0] b_din,
    input  logic [4:0] b_shamt,
    input  logic       b_lorr,
    input  logic       b_aorl,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_id,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] data_reg;
    logic [4:0] rem_reg;
    logic       lorr_reg, aorl_reg, id_reg, last_reg;

    logic       grant_a, grant_b;
    logic [2:0] step;
    logic [4:0] rem_left;
    logic [7:0] shifted;

    // A wins when alone, under fixed priority, or when B was granted last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_reg == IDLE) begin
            if (a_valid && (!b_valid || !RR || last_reg))
                grant_a = 1'b1;
            else if (b_valid)
                grant_b = 1'b1;
        end
    end

    assign step     = (rem_reg > 5'd7) ? 3'd7 : rem_reg[2:0];
    assign rem_left = rem_reg - {2'b00, step};

    always_comb begin
        if (lorr_reg)
            shifted = data_reg << step;
        else if (aorl_reg)
            shifted = $signed(data_reg) >>> step;
        else
            shifted = data_reg >> step;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_a)
                    state_next = (a_shamt == 5'd0) ? DONE : SHIFT;
                else if (grant_b)
                    state_next = (b_shamt == 5'd0) ? DONE : SHIFT;
            end
            SHIFT:   if (rem_left == 5'd0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= 8'h00;
            rem_reg   <= 5'd0;
            lorr_reg  <= 1'b0;
            aorl_reg  <= 1'b0;
            id_reg    <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (grant_a) begin
                data_reg <= a_din;
                rem_reg  <= a_shamt;
                lorr_reg <= a_lorr;
                aorl_reg <= a_aorl;
                id_reg   <= 1'b0;
                last_reg <= 1'b0;
            end else if (grant_b) begin
                data_reg <= b_din;
                rem_reg  <= b_shamt;
                lorr_reg <= b_lorr;
                aorl_reg <= b_aorl;
                id_reg   <= 1'b1;
                last_reg <= 1'b1;
            end else if (state_reg == SHIFT) begin
                data_reg <= shifted;
                rem_reg  <= rem_left;
            end
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign out_valid = (state_reg == DONE);
    assign out_data  = data_reg;
    assign out_id    = id_reg;
    assign busy      = (state_reg != IDLE);

endmodule
